instr_encoder: RTL and testbench

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/instr_encoder.sv | 142 ++++++++++++++
 tb/tb_instr_encoder.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// Instruction encoder: packs RV32I field bundles into 32-bit words and
// buffers them in a small FIFO. Illegal bundles are consumed, dropped and
// flagged with a one-cycle err_pulse plus a saturating error counter.
//
// Handshake rules (both sides): a transfer happens on a rising clk edge
// when valid and ready are both high. A producer holds its payload stable
// while valid is high and ready is low. in_ready is derived from the
// registered occupancy only, so there is no combinational path from
// out_ready to in_ready; out_instr holds stable while out_valid is high and
// out_ready is low.
module instr_encoder #(
   parameter int FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [2:0]  in_class,
   input  logic [4:0]  in_rd,
   input  logic [4:0]  in_rs1,
   input  logic [4:0]  in_rs2,
   input  logic [2:0]  in_funct3,
   input  logic [6:0]  in_funct7,
   input  logic [12:0] in_imm,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instr,
   output logic        err_pulse,
   output logic [7:0]  err_count,
   output logic [15:0] instr_count
);

   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

   logic [31:0]   mem_q [FIFO_DEPTH];
   logic [31:0]   mem_d [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          err_pulse_q, err_pulse_d;
   logic [7:0]    err_count_q, err_count_d;
   logic [15:0]   instr_count_q, instr_count_d;

   logic [31:0]   enc_word;
   logic          legal;
   logic          in_fire;
   logic          push;
   logic          pop;

   // Field packing and legality check per instruction class
   always_comb begin
      legal    = 1'b1;
      enc_word = '0;
      case (in_class)
         3'd0: enc_word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, 7'b0110011};
         3'd1: begin
            legal    = (in_imm[12] == in_imm[11]);
            enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'b0010011};
         end
         3'd2: begin
            legal    = (in_imm[12] == in_imm[11]);
            enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'b0000011};
         end
         3'd3: begin
            legal    = (in_imm[12] == in_imm[11]);
            enc_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], 7'b0100011};
         end
         3'd4: begin
            // Branch offsets are halfword aligned; bit 0 is not encodable
            legal    = ~in_imm[0];
            enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                        in_imm[4:1], in_imm[11], 7'b1100011};
         end
         default: legal = 1'b0;
      endcase
   end

   assign in_ready    = (count_q < DEPTH_C);
   assign out_valid   = (count_q != '0);
   assign out_instr   = mem_q[rd_ptr_q];
   assign err_pulse   = err_pulse_q;
   assign err_count   = err_count_q;
   assign instr_count = instr_count_q;

   assign in_fire = in_valid && in_ready;
   assign push    = in_fire && legal;
   assign pop     = out_valid && out_ready;

   // Next-state for FIFO pointers, occupancy and statistics
   always_comb begin
      mem_d         = mem_q;
      wr_ptr_d      = wr_ptr_q;
      rd_ptr_d      = rd_ptr_q;
      count_d       = count_q;
      err_pulse_d   = in_fire && !legal;
      err_count_d   = err_count_q;
      instr_count_d = instr_count_q;
      if (push) begin
         mem_d[wr_ptr_q] = enc_word;
         wr_ptr_d        = wr_ptr_q + 1'b1;
         instr_count_d   = instr_count_q + 16'd1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
      if (in_fire && !legal && (err_count_q != 8'hFF)) begin
         err_count_d = err_count_q + 8'd1;
      end
   end

   // Control and statistics registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         count_q       <= '0;
         err_pulse_q   <= 1'b0;
         err_count_q   <= '0;
         instr_count_q <= '0;
      end else begin
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         count_q       <= count_d;
         err_pulse_q   <= err_pulse_d;
         err_count_q   <= err_count_d;
         instr_count_q <= instr_count_d;
      end
   end

   // FIFO storage; contents are meaningless unless counted by occupancy
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: reset, per-class encodings, illegal
// bundle handling, FIFO full/back-pressure ordering and mid-run reset.
module tb_instr_encoder;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  in_class;
   logic [4:0]  in_rd;
   logic [4:0]  in_rs1;
   logic [4:0]  in_rs2;
   logic [2:0]  in_funct3;
   logic [6:0]  in_funct7;
   logic [12:0] in_imm;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic        err_pulse;
   logic [7:0]  err_count;
   logic [15:0] instr_count;

   int pass_cnt = 0;
   int total_cnt = 0;

   instr_encoder #(.FIFO_DEPTH(4)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_class(in_class), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
      .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
      .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
      .err_pulse(err_pulse), .err_count(err_count), .instr_count(instr_count)
   );

   // Clock
   always #5 clk = ~clk;

   // Advance one cycle and settle just after the edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_bundle(input logic [2:0] cls, input logic [4:0] rd,
                             input logic [4:0] rs1, input logic [4:0] rs2,
                             input logic [2:0] f3, input logic [6:0] f7,
                             input logic [12:0] imm);
      in_class  = cls;
      in_rd     = rd;
      in_rs1    = rs1;
      in_rs2    = rs2;
      in_funct3 = f3;
      in_funct7 = f7;
      in_imm    = imm;
   endtask

   // Present the current bundle until accepted (bounded), then drop valid
   task automatic send_bundle(input string name);
      int n;
      n = 0;
      in_valid = 1'b1;
      while (!in_ready && n < 20) begin
         step();
         n++;
      end
      total_cnt++;
      if (!in_ready) $display("FAIL %s accept_timeout in_ready=%0b required=1", name, in_ready);
      else pass_cnt++;
      step();
      in_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b0;
      set_bundle(3'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 13'd0);
      step();
      step();
      rst = 1'b0;
      total_cnt++;
      if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%0b exp=0", out_valid);
      else pass_cnt++;
      total_cnt++;
      if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%0b exp=1", in_ready);
      else pass_cnt++;
      total_cnt++;
      if (err_pulse !== 1'b0) $display("FAIL reset_err_pulse got=%0b exp=0", err_pulse);
      else pass_cnt++;
      total_cnt++;
      if (err_count !== 8'd0 || instr_count !== 16'd0)
         $display("FAIL reset_counts got=%0d/%0d exp=0/0", err_count, instr_count);
      else pass_cnt++;
   endtask

   task automatic test_r_type();
      out_ready = 1'b1;
      set_bundle(3'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 13'h1ABC);
      send_bundle("r_add");
      total_cnt++;
      if (out_valid !== 1'b1 || out_instr !== 32'h002081B3)
         $display("FAIL r_add got=%0b/%h exp=1/002081b3", out_valid, out_instr);
      else pass_cnt++;
      total_cnt++;
      if (instr_count !== 16'd1) $display("FAIL r_add_count got=%0d exp=1", instr_count);
      else pass_cnt++;
      step();
      total_cnt++;
      if (out_valid !== 1'b0) $display("FAIL r_add_drain got=%0b exp=0", out_valid);
      else pass_cnt++;
   endtask

   task automatic test_i_store();
      set_bundle(3'd1, 5'd5, 5'd0, 5'd31, 3'd0, 7'h7F, 13'h1FFF);
      send_bundle("addi");
      total_cnt++;
      if (out_valid !== 1'b1 || out_instr !== 32'hFFF00293)
         $display("FAIL addi got=%0b/%h exp=1/fff00293", out_valid, out_instr);
      else pass_cnt++;
      step();
      set_bundle(3'd3, 5'd17, 5'd1, 5'd2, 3'd2, 7'h55, 13'd8);
      send_bundle("sw");
      total_cnt++;
      if (out_valid !== 1'b1 || out_instr !== 32'h0020A423)
         $display("FAIL sw got=%0b/%h exp=1/0020a423", out_valid, out_instr);
      else pass_cnt++;
      step();
   endtask

   task automatic test_branch();
      set_bundle(3'd4, 5'd9, 5'd1, 5'd2, 3'd0, 7'd0, 13'd16);
      send_bundle("beq");
      total_cnt++;
      if (out_valid !== 1'b1 || out_instr !== 32'h00208863)
         $display("FAIL beq got=%0b/%h exp=1/00208863", out_valid, out_instr);
      else pass_cnt++;
      // beq word pops on the same edge that takes the odd-offset bundle
      set_bundle(3'd4, 5'd9, 5'd1, 5'd2, 3'd0, 7'd0, 13'd3);
      send_bundle("beq_odd");
      total_cnt++;
      if (err_pulse !== 1'b1 || out_valid !== 1'b0)
         $display("FAIL beq_odd_flag got=%0b/%0b exp=1/0", err_pulse, out_valid);
      else pass_cnt++;
      total_cnt++;
      if (err_count !== 8'd1 || instr_count !== 16'd4)
         $display("FAIL beq_odd_counts got=%0d/%0d exp=1/4", err_count, instr_count);
      else pass_cnt++;
      step();
      total_cnt++;
      if (err_pulse !== 1'b0) $display("FAIL err_pulse_width got=%0b exp=0", err_pulse);
      else pass_cnt++;
   endtask

   task automatic test_illegal();
      set_bundle(3'd5, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, 13'd0);
      send_bundle("class5");
      total_cnt++;
      if (err_pulse !== 1'b1) $display("FAIL class5_pulse got=%0b exp=1", err_pulse);
      else pass_cnt++;
      // Back-to-back rejection: pulse stays high for the second one
      set_bundle(3'd1, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, 13'h0800);
      send_bundle("imm_ovf");
      total_cnt++;
      if (err_pulse !== 1'b1 || out_valid !== 1'b0)
         $display("FAIL imm_ovf_flag got=%0b/%0b exp=1/0", err_pulse, out_valid);
      else pass_cnt++;
      total_cnt++;
      if (err_count !== 8'd3 || instr_count !== 16'd4)
         $display("FAIL illegal_counts got=%0d/%0d exp=3/4", err_count, instr_count);
      else pass_cnt++;
      // Negative 12-bit boundary: imm 0x1800 (-2048) is legal
      set_bundle(3'd2, 5'd4, 5'd6, 5'd0, 3'd2, 7'd0, 13'h1800);
      send_bundle("lw_neg");
      total_cnt++;
      if (out_valid !== 1'b1 || out_instr !== 32'h80032203 || err_pulse !== 1'b0)
         $display("FAIL lw_neg got=%0b/%h/%0b exp=1/80032203/0", out_valid, out_instr, err_pulse);
      else pass_cnt++;
      step();
   endtask

   task automatic test_back_to_back();
      logic [31:0] w [5];
      for (int i = 0; i < 5; i++) w[i] = (32'(i + 1) << 20) | (32'(i + 1) << 7) | 32'h13;
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         set_bundle(3'd1, 5'(i + 1), 5'd0, 5'd0, 3'd0, 7'd0, 13'(i + 1));
         send_bundle("fill");
      end
      total_cnt++;
      if (in_ready !== 1'b0) $display("FAIL full_in_ready got=%0b exp=0", in_ready);
      else pass_cnt++;
      set_bundle(3'd1, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 13'd5);
      in_valid = 1'b1;
      step();
      step();
      total_cnt++;
      if (instr_count !== 16'd9 || out_instr !== w[0])
         $display("FAIL full_hold got=%0d/%h exp=9/%h", instr_count, out_instr, w[0]);
      else pass_cnt++;
      out_ready = 1'b1;
      step();
      total_cnt++;
      if (out_instr !== w[1] || in_ready !== 1'b1)
         $display("FAIL order1 got=%h/%0b exp=%h/1", out_instr, in_ready, w[1]);
      else pass_cnt++;
      step();
      in_valid = 1'b0;
      total_cnt++;
      if (out_instr !== w[2] || instr_count !== 16'd10)
         $display("FAIL order2 got=%h/%0d exp=%h/10", out_instr, instr_count, w[2]);
      else pass_cnt++;
      step();
      total_cnt++;
      if (out_instr !== w[3]) $display("FAIL order3 got=%h exp=%h", out_instr, w[3]);
      else pass_cnt++;
      step();
      total_cnt++;
      if (out_valid !== 1'b1 || out_instr !== w[4])
         $display("FAIL order4 got=%0b/%h exp=1/%h", out_valid, out_instr, w[4]);
      else pass_cnt++;
      step();
      total_cnt++;
      if (out_valid !== 1'b0) $display("FAIL drained got=%0b exp=0", out_valid);
      else pass_cnt++;
   endtask

   task automatic test_reset_mid();
      out_ready = 1'b0;
      set_bundle(3'd0, 5'd7, 5'd8, 5'd9, 3'd0, 7'd0, 13'd0);
      send_bundle("pre_a");
      send_bundle("pre_b");
      set_bundle(3'd1, 5'd1, 5'd1, 5'd0, 3'd0, 7'd0, 13'd1);
      in_valid = 1'b1;
      rst = 1'b1;
      step();
      rst = 1'b0;
      in_valid = 1'b0;
      total_cnt++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1)
         $display("FAIL mid_rst_flags got=%0b/%0b exp=0/1", out_valid, in_ready);
      else pass_cnt++;
      total_cnt++;
      if (err_count !== 8'd0 || instr_count !== 16'd0)
         $display("FAIL mid_rst_counts got=%0d/%0d exp=0/0", err_count, instr_count);
      else pass_cnt++;
      out_ready = 1'b1;
      set_bundle(3'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 13'd0);
      send_bundle("post_rst");
      total_cnt++;
      if (out_valid !== 1'b1 || out_instr !== 32'h402081B3 || instr_count !== 16'd1)
         $display("FAIL post_rst got=%0b/%h/%0d exp=1/402081b3/1", out_valid, out_instr, instr_count);
      else pass_cnt++;
      step();
      total_cnt++;
      if (out_valid !== 1'b0) $display("FAIL post_rst_alone got=%0b exp=0", out_valid);
      else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_r_type();
      test_i_store();
      test_branch();
      test_illegal();
      test_back_to_back();
      test_reset_mid();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
